// File: rtl/regfile_pkg.sv
// Shared defaults and clear-sweep state encoding for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned NREGS_DEFAULT = 32;

  typedef enum logic {
    READY = 1'b0,
    SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep controller: walks idx 1..NREGS-1 one entry per cycle and gates ready_o.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear_i,
  output logic                     ready_o,
  output logic                     sweep_en_o,
  output logic [$clog2(NREGS)-1:0] sweep_idx_o
);

  localparam int unsigned ADDR_W = $clog2(NREGS);

  typedef logic [ADDR_W-1:0] adr_t;

  localparam adr_t LAST_IDX = ADDR_W'(NREGS - 1);

  state_e state_q, state_d;
  adr_t   idx_q, idx_d;
  logic   ready_q, ready_d;

  // Register 0 is hardwired, so the sweep starts at 1
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    unique case (state_q)
      READY: begin
        if (clear_i) begin
          state_d = SWEEP;
          idx_d   = ADDR_W'(1);
          ready_d = 1'b0;
        end
      end
      SWEEP: begin
        if (idx_q == LAST_IDX) begin
          state_d = READY;
          idx_d   = '0;
          ready_d = 1'b1;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = READY;
        idx_d   = '0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= READY;
      idx_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o     = ready_q;
  assign sweep_en_o  = (state_q == SWEEP);
  assign sweep_idx_o = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register pending bits, optional
// write-to-read bypass, hardwired zero register and a sequential clear sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned NREGS  = NREGS_DEFAULT,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 1,
  parameter int unsigned BYPASS = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NRD*$clog2(NREGS)-1:0] rd_adr_i,
  output logic [NRD*XLEN-1:0]          rd_data_o,
  output logic [NRD-1:0]               rd_pending_o,
  input  logic [NWR-1:0]               wr_valid_i,
  input  logic [NWR*$clog2(NREGS)-1:0] wr_adr_i,
  input  logic [NWR*XLEN-1:0]          wr_data_i,
  input  logic                         alloc_valid_i,
  input  logic [$clog2(NREGS)-1:0]     alloc_adr_i,
  input  logic                         clear_i,
  output logic                         ready_o
);

  localparam int unsigned ADDR_W = $clog2(NREGS);

  typedef logic [ADDR_W-1:0] adr_t;
  typedef logic [XLEN-1:0]   data_t;

  data_t            regs_q [NREGS];
  data_t            regs_d [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;

  logic             sweep_en;
  adr_t             sweep_idx;

  logic [NWR-1:0]   wr_acc;
  adr_t             wr_adr  [NWR];
  data_t            wr_data [NWR];
  logic             alloc_acc;

  regfile_clear_fsm #(
    .NREGS (NREGS)
  ) u_fsm (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (clear_i),
    .ready_o     (ready_o),
    .sweep_en_o  (sweep_en),
    .sweep_idx_o (sweep_idx)
  );

  // Per-port write qualification; writes to register 0 never take effect
  for (genvar k = 0; k < NWR; k++) begin : g_wr
    assign wr_adr[k]  = wr_adr_i[k*ADDR_W +: ADDR_W];
    assign wr_data[k] = wr_data_i[k*XLEN +: XLEN];
    assign wr_acc[k]  = ready_o && wr_valid_i[k] && (wr_adr[k] != '0);
  end

  assign alloc_acc = ready_o && alloc_valid_i && (alloc_adr_i != '0);

  // Ascending port order lets the highest index win; alloc applied last so the new producer wins
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (sweep_en) begin
      regs_d[sweep_idx] = '0;
      pend_d[sweep_idx] = 1'b0;
    end else begin
      for (int unsigned k = 0; k < NWR; k++) begin
        if (wr_acc[k]) begin
          regs_d[wr_adr[k]] = wr_data[k];
          pend_d[wr_adr[k]] = 1'b0;
        end
      end
      if (alloc_acc) begin
        pend_d[alloc_adr_i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  // Combinational read ports; a same-cycle alloc leaves the stored pending bit showing
  for (genvar j = 0; j < NRD; j++) begin : g_rd
    adr_t  ra;
    data_t rd_d;
    logic  rd_p;

    assign ra = rd_adr_i[j*ADDR_W +: ADDR_W];

    always_comb begin
      rd_d = regs_q[ra];
      rd_p = pend_q[ra];
      if (BYPASS != 0) begin
        for (int unsigned k = 0; k < NWR; k++) begin
          if (wr_acc[k] && (wr_adr[k] == ra)) begin
            rd_d = wr_data[k];
            if (!(alloc_acc && (alloc_adr_i == ra))) begin
              rd_p = 1'b0;
            end
          end
        end
      end
      if (!ready_o || (ra == '0)) begin
        rd_d = '0;
        rd_p = 1'b0;
      end
    end

    assign rd_data_o[j*XLEN +: XLEN] = rd_d;
    assign rd_pending_o[j]           = rd_p;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: bypassing and non-bypassing instances share stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  rd_adr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_pend, rd_pend_nb;
  logic [1:0]  wr_valid;
  logic [9:0]  wr_adr;
  logic [63:0] wr_data;
  logic        alloc_valid;
  logic [4:0]  alloc_adr;
  logic        clear;
  logic        ready, ready_nb;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    bit          nb;
    int          port;
    logic [31:0] d;
    logic        p;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .rd_adr_i(rd_adr), .rd_data_o(rd_data),
    .rd_pending_o(rd_pend), .wr_valid_i(wr_valid), .wr_adr_i(wr_adr),
    .wr_data_i(wr_data), .alloc_valid_i(alloc_valid), .alloc_adr_i(alloc_adr),
    .clear_i(clear), .ready_o(ready)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) u_dut_nb (
    .clk(clk), .reset_n(reset_n), .rd_adr_i(rd_adr), .rd_data_o(rd_data_nb),
    .rd_pending_o(rd_pend_nb), .wr_valid_i(wr_valid), .wr_adr_i(wr_adr),
    .wr_data_i(wr_data), .alloc_valid_i(alloc_valid), .alloc_adr_i(alloc_adr),
    .clear_i(clear), .ready_o(ready_nb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic exp_rd(input string tag, input bit nb, input int port,
                        input logic [31:0] d, input logic p);
    exp_t e;
    e.tag = tag; e.nb = nb; e.port = port; e.d = d; e.p = p;
    sb.push_back(e);
  endtask

  task automatic compare_sb();
    exp_t        e;
    logic [31:0] gd;
    logic        gp;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.nb) begin
        gd = rd_data_nb[e.port*32 +: 32];
        gp = rd_pend_nb[e.port];
      end else begin
        gd = rd_data[e.port*32 +: 32];
        gp = rd_pend[e.port];
      end
      chk({e.tag, "_data"}, gd, e.d);
      chk({e.tag, "_pend"}, 32'(gp), 32'(e.p));
    end
  endtask

  task automatic sample_chk();
    @(negedge clk);
    compare_sb();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid    = '0;
    wr_adr      = '0;
    wr_data     = '0;
    alloc_valid = 1'b0;
    alloc_adr   = '0;
    clear       = 1'b0;
  endtask

  task automatic wr(input int k, input int a, input logic [31:0] d);
    wr_valid[k]        = 1'b1;
    wr_adr[k*5 +: 5]   = 5'(a);
    wr_data[k*32 +: 32] = d;
  endtask

  task automatic alloc(input int a);
    alloc_valid = 1'b1;
    alloc_adr   = 5'(a);
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_adr = {5'(a1), 5'(a0)};
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      set_rd(a, 31 - a);
      exp_rd(tag, 1'b0, 0, 32'h0, 1'b0);
      exp_rd(tag, 1'b0, 1, 32'h0, 1'b0);
      exp_rd({tag, "_nb"}, 1'b1, 0, 32'h0, 1'b0);
      sample_chk();
      chk({tag, "_ready"}, 32'(ready), 32'h1);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset_n = 1'b0;
    idle();
    set_rd(0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_ready_nb", 32'(ready_nb), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    read_all_zero("reset_rd");

    // Basic write, then stored read
    wr(0, 5, 32'hDEADBEEF);
    set_rd(0, 0);
    step();
    idle();
    set_rd(5, 0);
    exp_rd("wr5", 1'b0, 0, 32'hDEADBEEF, 1'b0);
    exp_rd("wr5_nb", 1'b1, 0, 32'hDEADBEEF, 1'b0);
    sample_chk();
    step();

    // Register 0 ignores writes, even on the bypass path
    wr(0, 0, 32'h1234);
    set_rd(0, 0);
    exp_rd("r0_same", 1'b0, 0, 32'h0, 1'b0);
    exp_rd("r0_same", 1'b0, 1, 32'h0, 1'b0);
    sample_chk();
    step();
    idle();
    exp_rd("r0_after", 1'b0, 0, 32'h0, 1'b0);
    sample_chk();
    step();

    // Two ports hit reg 7: port 1 wins
    wr(0, 7, 32'h11);
    wr(1, 7, 32'h22);
    set_rd(7, 0);
    exp_rd("conf_byp", 1'b0, 0, 32'h22, 1'b0);
    exp_rd("conf_nobyp", 1'b1, 0, 32'h0, 1'b0);
    sample_chk();
    step();
    idle();
    exp_rd("conf_st", 1'b0, 0, 32'h22, 1'b0);
    exp_rd("conf_st_nb", 1'b1, 0, 32'h22, 1'b0);
    sample_chk();
    step();

    // Pending bit lifecycle on reg 3
    alloc(3);
    set_rd(0, 3);
    exp_rd("alloc_same", 1'b0, 1, 32'h0, 1'b0);
    sample_chk();
    step();
    idle();
    exp_rd("alloc_next", 1'b0, 1, 32'h0, 1'b1);
    exp_rd("alloc_next_nb", 1'b1, 1, 32'h0, 1'b1);
    sample_chk();
    step();
    wr(0, 3, 32'hAA);
    exp_rd("wr3_byp", 1'b0, 1, 32'hAA, 1'b0);
    exp_rd("wr3_nobyp", 1'b1, 1, 32'h0, 1'b1);
    sample_chk();
    step();
    idle();
    exp_rd("wr3_st", 1'b0, 1, 32'hAA, 1'b0);
    sample_chk();
    step();
    wr(0, 3, 32'hBB);
    alloc(3);
    exp_rd("aw3_byp", 1'b0, 1, 32'hBB, 1'b0);
    exp_rd("aw3_nobyp", 1'b1, 1, 32'hAA, 1'b0);
    sample_chk();
    step();
    idle();
    exp_rd("aw3_st", 1'b0, 1, 32'hBB, 1'b1);
    exp_rd("aw3_st_nb", 1'b1, 1, 32'hBB, 1'b1);
    sample_chk();
    step();
    alloc(0);
    wr(1, 0, 32'h55);
    set_rd(0, 0);
    step();
    idle();
    exp_rd("alloc_r0", 1'b0, 0, 32'h0, 1'b0);
    sample_chk();
    step();

    // Fill regs 1..31 and mark reg 9 pending
    for (int r = 1; r < 32; r++) begin
      wr(1, r, 32'hA500_0000 | 32'(r));
      step();
    end
    idle();
    alloc(9);
    step();
    idle();
    set_rd(31, 9);
    exp_rd("fill31", 1'b0, 0, 32'hA500_001F, 1'b0);
    exp_rd("fill9", 1'b0, 1, 32'hA500_0009, 1'b1);
    sample_chk();
    step();

    // Sweep: measure ready_o low time while hammering writes/allocs/clear
    clear = 1'b1;
    step();
    idle();
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      wr(0, (c % 31) + 1, 32'hBAD0_0000 | 32'(c));
      wr(1, ((c + 7) % 31) + 1, 32'hBEE0_0000 | 32'(c));
      alloc((c % 31) + 1);
      clear = (c == 10);
      set_rd(5, 9);
      @(negedge clk);
      if (ready) begin
        break;
      end
      cnt++;
      if (c == 4) begin
        exp_rd("sweep_rd", 1'b0, 0, 32'h0, 1'b0);
        exp_rd("sweep_rd", 1'b0, 1, 32'h0, 1'b0);
        compare_sb();
      end
      @(posedge clk);
      #1;
    end
    idle();
    chk("sweep_len", 32'(cnt), 32'd31);
    step();
    read_all_zero("post_sweep");

    // Reset at sweep index 10
    wr(0, 5, 32'h5555_0005);
    wr(1, 20, 32'h2020_0014);
    step();
    idle();
    alloc(9);
    wr(0, 12, 32'h1212_000C);
    step();
    idle();
    clear = 1'b1;
    step();
    idle();
    repeat (9) step();
    chk("idx_at_10", 32'(u_dut.u_fsm.sweep_idx_o), 32'd10);
    chk("ready_pre_rst", 32'(ready), 32'h0);
    reset_n = 1'b0;
    #1;
    chk("ready_in_rst", 32'(ready), 32'h1);
    set_rd(20, 9);
    #1;
    exp_rd("rst_r20", 1'b0, 0, 32'h0, 1'b0);
    exp_rd("rst_r9", 1'b0, 1, 32'h0, 1'b0);
    compare_sb();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    read_all_zero("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
